// File: rtl/addr_mode_seq.sv
// addr_mode_seq: 6502 addressing-mode bus-cycle sequencer.
// Runs operand/pointer/dummy reads and returns the effective address.
module addr_mode_seq #(
    parameter int ADDR_N = 16,
    parameter int DATA_N = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        mode,
    input  logic [ADDR_N-1:0] pc,
    input  logic [DATA_N-1:0] x,
    input  logic [DATA_N-1:0] y,
    input  logic              is_store,
    input  logic              rdy,
    input  logic [DATA_N-1:0] rdata,
    output logic [ADDR_N-1:0] addr,
    output logic              rd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_N-1:0] ea,
    output logic              ea_valid,
    output logic              page_cross,
    output logic [1:0]        oper_len
);
    localparam int HI_N = ADDR_N - DATA_N;

    localparam logic [3:0] M_IMP  = 4'd0;
    localparam logic [3:0] M_IMM  = 4'd1;
    localparam logic [3:0] M_IND  = 4'd2;
    localparam logic [3:0] M_INDX = 4'd3;
    localparam logic [3:0] M_INDY = 4'd4;
    localparam logic [3:0] M_ZPG  = 4'd5;
    localparam logic [3:0] M_ZPGX = 4'd6;
    localparam logic [3:0] M_ZPGY = 4'd7;
    localparam logic [3:0] M_ABS  = 4'd8;
    localparam logic [3:0] M_ABSX = 4'd9;
    localparam logic [3:0] M_ABSY = 4'd10;
    localparam logic [3:0] M_RLT  = 4'd11;

    localparam logic [DATA_N-1:0] ONE_D = DATA_N'(1);
    localparam logic [ADDR_N-1:0] ONE_A = ADDR_N'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_LO,
        S_OP_HI,
        S_PTR_LO,
        S_PTR_HI,
        S_DUMMY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        mode_q, mode_d;
    logic [ADDR_N-1:0] pc_q, pc_d;
    logic [DATA_N-1:0] idx_q, idx_d;
    logic              store_q, store_d;
    logic [DATA_N-1:0] lo_q, lo_d;
    logic [DATA_N-1:0] hi_q, hi_d;
    logic [ADDR_N-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_N-1:0] ea_q, ea_d;
    logic              ea_valid_q, ea_valid_d;
    logic              page_cross_q, page_cross_d;
    logic [1:0]        oper_len_q, oper_len_d;

    logic              fin;
    logic [ADDR_N-1:0] fin_ea;
    logic              fin_cross;
    logic [3:0]        fin_mode;
    logic              go;
    state_e            go_state;
    logic [ADDR_N-1:0] go_addr;
    logic [ADDR_N-1:0] sum_q;
    logic              cross_q;
    logic [ADDR_N-1:0] sum_rd;
    logic              cross_rd;
    logic [ADDR_N-1:0] npc;
    logic [ADDR_N-1:0] rel;

    function automatic logic [ADDR_N-1:0] zp(input logic [DATA_N-1:0] z);
        return {{HI_N{1'b0}}, z};
    endfunction

    function automatic logic [ADDR_N-1:0] idx_add(
        input logic [DATA_N-1:0] h,
        input logic [DATA_N-1:0] l,
        input logic [DATA_N-1:0] i
    );
        return {h, l} + {{HI_N{1'b0}}, i};
    endfunction

    function automatic logic use_x(input logic [3:0] m);
        return (m == M_INDX) || (m == M_ZPGX) || (m == M_ABSX);
    endfunction

    function automatic logic [1:0] len_of(input logic [3:0] m);
        if (m == M_ABS || m == M_ABSX || m == M_ABSY || m == M_IND)
            return 2'd2;
        else if (m == M_IMP || m > M_RLT)
            return 2'd0;
        else
            return 2'd1;
    endfunction

    assign addr       = addr_q;
    assign rd         = rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ea         = ea_q;
    assign ea_valid   = ea_valid_q;
    assign page_cross = page_cross_q;
    assign oper_len   = oper_len_q;

    // Next-state logic: pick the next bus cycle or finish with the EA.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        pc_d         = pc_q;
        idx_d        = idx_q;
        store_d      = store_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ea_d         = ea_q;
        ea_valid_d   = ea_valid_q;
        page_cross_d = page_cross_q;
        oper_len_d   = oper_len_q;

        fin       = 1'b0;
        fin_ea    = '0;
        fin_cross = 1'b0;
        fin_mode  = mode_q;
        go        = 1'b0;
        go_state  = S_IDLE;
        go_addr   = '0;

        sum_q    = idx_add(hi_q, lo_q, idx_q);
        cross_q  = sum_q[ADDR_N-1:DATA_N] != hi_q;
        sum_rd   = idx_add(rdata, lo_q, idx_q);
        cross_rd = sum_rd[ADDR_N-1:DATA_N] != rdata;
        npc      = pc_q + ONE_A;
        rel      = npc + {{HI_N{rdata[DATA_N-1]}}, rdata};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    pc_d       = pc;
                    idx_d      = use_x(mode) ? x : y;
                    store_d    = is_store;
                    busy_d     = 1'b1;
                    ea_valid_d = 1'b0;
                    fin_mode   = mode;
                    if (mode == M_IMM) begin
                        fin    = 1'b1;
                        fin_ea = pc;
                    end else if (mode == M_IMP || mode > M_RLT) begin
                        fin = 1'b1;
                    end else begin
                        go       = 1'b1;
                        go_state = S_OP_LO;
                        go_addr  = pc;
                    end
                end
            end
            S_OP_LO: begin
                if (rdy) begin
                    lo_d = rdata;
                    case (mode_q)
                        M_ZPG: begin
                            fin    = 1'b1;
                            fin_ea = zp(rdata);
                        end
                        M_ZPGX, M_ZPGY, M_INDX: begin
                            go       = 1'b1;
                            go_state = S_DUMMY;
                            go_addr  = zp(rdata);
                        end
                        M_INDY: begin
                            go       = 1'b1;
                            go_state = S_PTR_LO;
                            go_addr  = zp(rdata);
                        end
                        M_RLT: begin
                            fin       = 1'b1;
                            fin_ea    = rel;
                            fin_cross = rel[ADDR_N-1:DATA_N]
                                        != npc[ADDR_N-1:DATA_N];
                        end
                        default: begin
                            go       = 1'b1;
                            go_state = S_OP_HI;
                            go_addr  = npc;
                        end
                    endcase
                end
            end
            S_OP_HI: begin
                if (rdy) begin
                    hi_d = rdata;
                    if (mode_q == M_ABS) begin
                        fin    = 1'b1;
                        fin_ea = {rdata, lo_q};
                    end else if (mode_q == M_IND) begin
                        go       = 1'b1;
                        go_state = S_PTR_LO;
                        go_addr  = {rdata, lo_q};
                    end else if (cross_rd || store_q) begin
                        go       = 1'b1;
                        go_state = S_DUMMY;
                        go_addr  = {rdata, lo_q + idx_q};
                    end else begin
                        fin    = 1'b1;
                        fin_ea = sum_rd;
                    end
                end
            end
            S_PTR_LO: begin
                // The low-byte increment never carries: NMOS pointer wrap.
                if (rdy) begin
                    lo_d     = rdata;
                    go       = 1'b1;
                    go_state = S_PTR_HI;
                    go_addr  = {addr_q[ADDR_N-1:DATA_N],
                                addr_q[DATA_N-1:0] + ONE_D};
                end
            end
            S_PTR_HI: begin
                if (rdy) begin
                    hi_d = rdata;
                    if (mode_q != M_INDY) begin
                        fin    = 1'b1;
                        fin_ea = {rdata, lo_q};
                    end else if (cross_rd || store_q) begin
                        go       = 1'b1;
                        go_state = S_DUMMY;
                        go_addr  = {rdata, lo_q + idx_q};
                    end else begin
                        fin       = 1'b1;
                        fin_ea    = sum_rd;
                    end
                end
            end
            S_DUMMY: begin
                if (rdy) begin
                    case (mode_q)
                        M_ZPGX, M_ZPGY: begin
                            fin    = 1'b1;
                            fin_ea = zp(lo_q + idx_q);
                        end
                        M_INDX: begin
                            go       = 1'b1;
                            go_state = S_PTR_LO;
                            go_addr  = zp(lo_q + idx_q);
                        end
                        default: begin
                            fin       = 1'b1;
                            fin_ea    = sum_q;
                            fin_cross = cross_q;
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_OP_HI || state_q == S_PTR_HI) && fin)
            fin_cross = (mode_q == M_ABS || mode_q == M_IND
                         || mode_q == M_INDX) ? 1'b0 : cross_rd;

        if (go) begin
            state_d = go_state;
            addr_d  = go_addr;
            rd_d    = 1'b1;
        end
        if (fin) begin
            state_d      = S_DONE;
            rd_d         = 1'b0;
            done_d       = 1'b1;
            ea_d         = fin_ea;
            ea_valid_d   = 1'b1;
            page_cross_d = fin_cross;
            oper_len_d   = len_of(fin_mode);
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            pc_q         <= '0;
            idx_q        <= '0;
            store_q      <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ea_q         <= '0;
            ea_valid_q   <= 1'b0;
            page_cross_q <= 1'b0;
            oper_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            store_q      <= store_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ea_q         <= ea_d;
            ea_valid_q   <= ea_valid_d;
            page_cross_q <= page_cross_d;
            oper_len_q   <= oper_len_d;
        end
    end

endmodule

// File: tb/tb_addr_mode_seq.sv
// tb_addr_mode_seq: directed bench for the addressing-mode sequencer.
// Bus memory, arithmetic reference model and per-cycle compare.
module tb_addr_mode_seq;
    logic        clk = 1'b0;
    logic        reset, start, is_store, rdy;
    logic [3:0]  mode;
    logic [15:0] pc, addr, ea;
    logic [7:0]  x, y, rdata;
    logic        rd, busy, done, ea_valid, page_cross;
    logic [1:0]  oper_len;

    logic [7:0]  mem [0:65535];
    int          tests = 0;
    int          fails = 0;
    logic        chk_en = 1'b0;
    int          q_addr[$];
    int          exp_ea, exp_len;
    logic        exp_cross;

    always #5 clk = ~clk;

    assign rdata = rd ? mem[addr] : 8'hA5;

    addr_mode_seq #(.ADDR_N(16), .DATA_N(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .pc(pc), .x(x), .y(y), .is_store(is_store), .rdy(rdy),
        .rdata(rdata), .addr(addr), .rd(rd), .busy(busy),
        .done(done), .ea(ea), .ea_valid(ea_valid),
        .page_cross(page_cross), .oper_len(oper_len)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: list of bus reads and final EA from the mode rules.
    task automatic build_model(input int m, input int p, input int xi,
                               input int yi, input bit st);
        int z, lo, hi, s, pa, pb, n, off, idx, p1;
        p1 = (p + 1) % 65536;
        q_addr.delete();
        exp_ea = 0;
        exp_len = 1;
        exp_cross = 1'b0;
        case (m)
            1: exp_ea = p;
            5: begin
                q_addr.push_back(p);
                exp_ea = mem[p];
            end
            6, 7: begin
                z = mem[p];
                idx = (m == 6) ? xi : yi;
                q_addr.push_back(p);
                q_addr.push_back(z);
                exp_ea = (z + idx) % 256;
            end
            2, 8, 9, 10: begin
                lo = mem[p];
                hi = mem[p1];
                q_addr.push_back(p);
                q_addr.push_back(p1);
                exp_len = 2;
                if (m == 8) begin
                    exp_ea = hi * 256 + lo;
                end else if (m == 2) begin
                    pa = hi * 256 + lo;
                    pb = hi * 256 + (lo + 1) % 256;
                    q_addr.push_back(pa);
                    q_addr.push_back(pb);
                    exp_ea = mem[pb] * 256 + mem[pa];
                end else begin
                    idx = (m == 9) ? xi : yi;
                    s = (hi * 256 + lo + idx) % 65536;
                    exp_cross = (s / 256) != hi;
                    if (exp_cross || st)
                        q_addr.push_back(hi * 256 + (lo + idx) % 256);
                    exp_ea = s;
                end
            end
            3: begin
                z = mem[p];
                pa = (z + xi) % 256;
                pb = (z + xi + 1) % 256;
                q_addr.push_back(p);
                q_addr.push_back(z);
                q_addr.push_back(pa);
                q_addr.push_back(pb);
                exp_ea = mem[pb] * 256 + mem[pa];
            end
            4: begin
                z = mem[p];
                pb = (z + 1) % 256;
                q_addr.push_back(p);
                q_addr.push_back(z);
                q_addr.push_back(pb);
                lo = mem[z];
                hi = mem[pb];
                s = (hi * 256 + lo + yi) % 65536;
                exp_cross = (s / 256) != hi;
                if (exp_cross || st)
                    q_addr.push_back(hi * 256 + (lo + yi) % 256);
                exp_ea = s;
            end
            11: begin
                off = mem[p];
                if (off >= 128) off = off - 256;
                q_addr.push_back(p);
                n = p1;
                exp_ea = (n + off + 65536) % 65536;
                exp_cross = (n / 256) != (exp_ea / 256);
            end
            default: exp_len = 0;
        endcase
    endtask

    // Per-cycle compare of bus reads and completion against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            if (rd === 1'b1) begin
                if (q_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_read: addr %0h, none expected",
                             addr);
                end else begin
                    chk("read_addr", addr, q_addr[0]);
                    if (rdy) void'(q_addr.pop_front());
                end
            end
            if (done === 1'b1) begin
                chk("done_ea", ea, exp_ea);
                chk("done_cross", page_cross, exp_cross);
                chk("done_len", oper_len, exp_len);
                chk("done_ea_valid", ea_valid, 1);
                chk("done_rd", rd, 0);
                chk("reads_left", q_addr.size(), 0);
            end
        end
    end

    task automatic run_txn(input string nm, input int m, input int p,
                           input int xi, input int yi, input bit st,
                           input int stall_at, input int stall_n,
                           input bit hold, input int lit_ea,
                           input bit lit_cross, input int lit_lat);
        int lat, exp_lat, nreads;
        build_model(m, p, xi, yi, st);
        nreads = q_addr.size();
        exp_lat = nreads + 1 + stall_n;
        chk_en = 1'b1;
        mode = 4'(m);
        pc = 16'(p);
        x = 8'(xi);
        y = 8'(yi);
        is_store = st;
        start = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (!hold) start = 1'b0;
            mode = 4'hF;
            pc = 16'h5A5A;
            x = 8'hC3;
            y = 8'h3C;
            is_store = ~st;
            if (lat == 1 && nreads > 0) begin
                chk({nm, "/ea_valid_clr"}, ea_valid, 0);
                chk({nm, "/busy"}, busy, 1);
            end
            if (done === 1'b1) break;
            if (lat > 64) begin
                tests++;
                fails++;
                $display("FAIL %s/timeout: no done after %0d cycles",
                         nm, lat);
                break;
            end
            rdy = (lat >= stall_at && lat < stall_at + stall_n)
                  ? 1'b0 : 1'b1;
        end
        start = 1'b0;
        rdy = 1'b1;
        chk({nm, "/latency"}, lat, lit_lat);
        chk({nm, "/model_latency"}, lat, exp_lat);
        @(posedge clk);
        #1;
        chk({nm, "/busy_after"}, busy, 0);
        chk({nm, "/done_after"}, done, 0);
        chk({nm, "/ea_valid_held"}, ea_valid, 1);
        chk({nm, "/ea"}, ea, lit_ea);
        chk({nm, "/cross"}, page_cross, lit_cross);
        chk({nm, "/len"}, oper_len, exp_len);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7 + 3) & 255);
        mem[16'h8000] = 8'h34; mem[16'h8001] = 8'h12;
        mem[16'h8010] = 8'hF0; mem[16'h8011] = 8'h12;
        mem[16'h8020] = 8'hF0;
        mem[16'h8030] = 8'hFF; mem[16'h8031] = 8'h02;
        mem[16'h02FF] = 8'h00; mem[16'h0200] = 8'h03;
        mem[16'h0300] = 8'hEE;
        mem[16'h8040] = 8'hFF; mem[16'h00FF] = 8'hFF;
        mem[16'h0000] = 8'h10;
        mem[16'h8050] = 8'h40; mem[16'h0040] = 8'h20;
        mem[16'h0041] = 8'h30;
        mem[16'h8060] = 8'hFE;
        mem[16'h8070] = 8'h42;
        mem[16'h80FE] = 8'h80;
        mem[16'h90FE] = 8'h05;
        mem[16'hA000] = 8'hFD;

        reset = 1'b1;
        start = 1'b0;
        rdy = 1'b1;
        mode = 4'd0;
        pc = 16'h0;
        x = 8'h0;
        y = 8'h0;
        is_store = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/addr", addr, 0);
        chk("rst/rd", rd, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/ea", ea, 0);
        chk("rst/ea_valid", ea_valid, 0);
        chk("rst/cross", page_cross, 0);
        chk("rst/len", oper_len, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_txn("abs", 8, 'h8000, 0, 0, 0, 0, 0, 0, 'h1234, 0, 3);
        run_txn("absx_cross", 9, 'h8010, 'h20, 0, 0, 0, 0, 0,
                'h1310, 1, 4);
        run_txn("absx_nocross", 9, 'h8010, 'h05, 0, 0, 0, 0, 0,
                'h12F5, 0, 3);
        run_txn("absx_store", 9, 'h8010, 'h05, 0, 1, 0, 0, 0,
                'h12F5, 0, 4);
        run_txn("absy_cross", 10, 'h8010, 0, 'h20, 0, 0, 0, 0,
                'h1310, 1, 4);
        run_txn("zpgx_wrap", 6, 'h8020, 'h20, 0, 0, 0, 0, 0,
                'h0010, 0, 3);
        run_txn("zpgy", 7, 'h8020, 0, 'h05, 0, 0, 0, 0, 'h00F5, 0, 3);
        run_txn("zpg", 5, 'h8070, 0, 0, 0, 0, 0, 0, 'h0042, 0, 2);
        run_txn("ind_bug", 2, 'h8030, 0, 0, 0, 0, 0, 0, 'h0300, 0, 5);
        run_txn("indx_wrap", 3, 'h8060, 'h01, 0, 0, 0, 0, 0,
                'h10FF, 0, 5);
        run_txn("indy_cross", 4, 'h8040, 0, 'h01, 0, 0, 0, 0,
                'h1100, 1, 5);
        run_txn("indy_store", 4, 'h8050, 0, 'h02, 1, 0, 0, 0,
                'h3022, 0, 5);
        run_txn("indy_plain", 4, 'h8050, 0, 'h02, 0, 0, 0, 0,
                'h3022, 0, 4);
        run_txn("rlt_back", 11, 'h80FE, 0, 0, 0, 0, 0, 0, 'h807F, 0, 2);
        run_txn("rlt_fwd_cross", 11, 'h90FE, 0, 0, 0, 0, 0, 0,
                'h9104, 1, 2);
        run_txn("rlt_back_cross", 11, 'hA000, 0, 0, 0, 0, 0, 0,
                'h9FFE, 1, 2);
        run_txn("imp", 0, 'h4321, 0, 0, 0, 0, 0, 0, 'h0000, 0, 1);
        run_txn("mode13", 13, 'h4321, 0, 0, 0, 0, 0, 0, 'h0000, 0, 1);
        run_txn("imm", 1, 'h1234, 0, 0, 0, 0, 0, 0, 'h1234, 0, 1);
        run_txn("abs_stall", 8, 'h8000, 0, 0, 0, 2, 3, 0, 'h1234, 0, 6);
        run_txn("abs_hold", 8, 'h8000, 0, 0, 0, 0, 0, 1, 'h1234, 0, 3);

        build_model(2, 'h8030, 0, 0, 0);
        chk_en = 1'b1;
        mode = 4'd2;
        pc = 16'h8030;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("rst_mid/rd_before", rd, 1);
        chk("rst_mid/addr_before", addr, 'h02FF);
        chk_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/rd", rd, 0);
        chk("rst_mid/ea_valid", ea_valid, 0);
        chk("rst_mid/done", done, 0);
        chk("rst_mid/ea", ea, 0);
        reset = 1'b0;
        q_addr.delete();
        @(posedge clk);
        #1;
        run_txn("after_rst", 9, 'h8010, 'h20, 0, 0, 0, 0, 0,
                'h1310, 1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
